conv_input_streamer: RTL and testbench
======================================

# conv_input_streamer

Feature-map reader that streams one layer's input activations into the convolution engine's AXI-Stream slave port. It reads 16-bit pixels from a feature-map BRAM in channel-major, row-major, column-minor order and drives an AXI-Stream master at up to one pixel per cycle. It absorbs the BRAM read latency and downstream backpressure with a 2-entry buffer. It marks the last pixel of each channel plane with TLAST.

## Interface

Parameters:
- ADDR_WIDTH, 22, feature-map BRAM word-address width (covers 256 × 128 × 128 pixels)
- PIXEL_WIDTH, 16, pixel width

Ports:
- clk  in  1  single clock; all logic on rising edge
- aresetn  in  1  reset; synchronous, active-low
- start  in  1  one-cycle request to stream a full feature map; sampled only in IDLE
- Image_size  in  8  pixels per row = rows per plane (N); sampled on accepted start
- Channel_size  in  9  number of channel planes (C); sampled on accepted start
- busy  out  1  high from accepted start until the done pulse, inclusive
- done  out  1  one-cycle pulse after the final beat handshakes
- fmap_BRAM_en  out  1  read enable; 1-cycle read latency
- fmap_BRAM_addr  out  ADDR_WIDTH  read word address
- fmap_BRAM_dout  in  PIXEL_WIDTH  read data, valid the cycle after en
- m_axis_tdata  out  PIXEL_WIDTH  pixel
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  sink ready
- m_axis_tlast  out  1  last pixel of the current channel plane

## Operation

- FSM states:
  - IDLE: accepted start with N≠0 and C≠0 → RUN; with N=0 or C=0 → DONE.
  - RUN: issues reads; after the read of address C·N·N−1 is issued → DRAIN.
  - DRAIN: waits until no read is in flight and the buffer is empty → DONE.
  - DONE: lasts one cycle, done=1 → IDLE.
- Counters:
  - Linear read address starts at 0 and increments by 1 per issued read.
  - col (0..N−1) wraps into row (0..N−1), which wraps into ch (0..C−1).
  - Tag each read with last = (col==N−1 && row==N−1).
- The buffer is a 2-entry FIFO of {last, data}. It is written the cycle fmap_BRAM_dout is valid.
- Read issue rule, in RUN only: fmap_BRAM_en = (count + inflight − pop) < 2, where pop = tvalid && tready this cycle and inflight ∈ {0,1}.
  - This guarantees the FIFO never overflows.
  - It sustains 1 beat/cycle while tready=1.
- AXIS:
  - tvalid = FIFO non-empty.
  - tdata/tlast = FIFO head.
  - Once tvalid=1, tdata, tlast and tvalid stay stable until the handshake.
- start while busy is ignored. Image_size/Channel_size changes while busy have no effect.
- The product C·N·N is computed at full width (9+8+8 = 25 bits). The team guarantees C·N·N ≤ 2^ADDR_WIDTH; the block does not check it.
- Reset (aresetn=0 at an edge), including mid-stream:
  - Return to IDLE; clear the FIFO, inflight flag and all counters.
  - Data returning from a read issued before reset is discarded.
- Reset values: busy=0, done=0, fmap_BRAM_en=0, fmap_BRAM_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.

## Timing

- Start accepted at edge t:
  - RUN in cycle t+1 with en=1, addr=0.
  - Data is written to the FIFO at the end of t+2.
  - First tvalid=1 in cycle t+3.
- With tready held at 1: one beat per cycle, no bubbles, C·N·N consecutive beats.
- With tready=0 from the first beat onward: exactly 2 reads complete, then en stays 0 until a pop.
- Final handshake at edge h: done=1 and busy=1 in cycle h+1; busy=0 in cycle h+2.
- Zero-size start accepted at edge t: done=1 in cycle t+1. No BRAM reads and no beats.
- All outputs are registered or decoded from registered state. There is no combinational path from m_axis_tready to m_axis_tvalid; the path from m_axis_tready to fmap_BRAM_en is permitted.

## Structure

- Shared package conv_stream_pkg holds:
  - FSM state localparams (IDLE, RUN, DRAIN, DONE)
  - default ADDR_WIDTH and PIXEL_WIDTH
  - the FIFO entry width (PIXEL_WIDTH+1)
- The sub-module stream_fifo2 is a 2-entry synchronous FIFO with count output. It has synchronous active-low reset and allows simultaneous push and pop when full.
- The top level holds the FSM, address/col/row/ch counters, the inflight flag and the issue logic.

## Test plan

- N=2, C=2, mem[i]=i+0x100, tready=1: 8 beats 0x100..0x107 on consecutive cycles; tlast on beats 4 and 8 only; first tvalid 3 cycles after start; done 1 cycle after the last beat.
- Same config, tready following a pseudo-random 50% pattern: exact sequence 0x100..0x107 with no loss or duplication; tdata/tlast stable while tvalid && !tready.
- N=4, C=1, tready=0 for 10 cycles, then 1: exactly 2 en pulses during the stall; 16 beats in order afterward; tlast on beat 16.
- start pulsed again mid-stream, with Image_size changed to 8: ignored; the stream completes with the original 16 beats and a single done.
- aresetn=0 for 1 cycle after 5 beats of N=4, C=2: all outputs return to reset values next cycle; a new start then streams from 0x100 with no stale beat.
- Image_size=0 or Channel_size=0: done pulses 1 cycle after start; en and tvalid never assert.

Source files
------------

// File: rtl/conv_stream_pkg.sv
// rtl/conv_stream_pkg.sv - shared types and constants for the feature-map streamer
package conv_stream_pkg;

  localparam int ADDR_WIDTH_DEF  = 22;
  localparam int PIXEL_WIDTH_DEF = 16;
  localparam int ENTRY_WIDTH     = PIXEL_WIDTH_DEF + 1;
  // C*N*N at full width: 9 + 8 + 8 bits
  localparam int TOTAL_WIDTH     = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int entry_width(input int pixel_width);
    return pixel_width + 1;
  endfunction

endpackage

// File: rtl/conv_input_streamer_if.sv
// rtl/conv_input_streamer_if.sv - pixel stream bundle between streamer and conv engine
interface conv_input_streamer_if
  import conv_stream_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF
) ();

  logic [PIXEL_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - 2-entry synchronous FIFO with occupancy count
module stream_fifo2
  import conv_stream_pkg::*;
#(
  parameter int W = ENTRY_WIDTH
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_q;
  logic         wr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/conv_input_streamer.sv
// rtl/conv_input_streamer.sv - streams a C x N x N feature map from BRAM onto a pixel stream
module conv_input_streamer
  import conv_stream_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   start,
  input  logic [7:0]             Image_size,
  input  logic [8:0]             Channel_size,
  output logic                   busy,
  output logic                   done,
  output logic                   fmap_BRAM_en,
  output logic [ADDR_WIDTH-1:0]  fmap_BRAM_addr,
  input  logic [PIXEL_WIDTH-1:0] fmap_BRAM_dout,
  conv_input_streamer_if.master  m_axis
);

  localparam int EW = entry_width(PIXEL_WIDTH);

  state_t                 state_q;
  logic [7:0]             n_q;
  logic [8:0]             c_q;
  logic [TOTAL_WIDTH-1:0] total_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [7:0]             col_q;
  logic [7:0]             row_q;
  logic [8:0]             ch_q;
  logic                   inflight_q;
  logic                   inflight_last_q;

  logic [1:0]             count;
  logic [EW-1:0]          head;
  logic                   fifo_valid;
  logic                   pop;
  logic [2:0]             occ;
  logic                   issue;
  logic                   tag_last;
  logic                   final_read;
  logic                   drained;

  assign fifo_valid = (count != 2'd0);
  assign pop        = fifo_valid && m_axis.tready;
  assign occ        = {1'b0, count} + {2'b0, inflight_q};
  // occupancy after this cycle's pop must leave room for the read being issued
  assign issue      = (state_q == ST_RUN) && (occ < (pop ? 3'd3 : 3'd2));
  assign tag_last   = (col_q == n_q - 8'd1) && (row_q == n_q - 8'd1);
  assign final_read = (TOTAL_WIDTH'(addr_q) == total_q - TOTAL_WIDTH'(1));
  // look one edge ahead so done follows the final handshake by a single cycle
  assign drained    = !inflight_q && ((count == 2'd0) || ((count == 2'd1) && pop));

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q         <= ST_IDLE;
      n_q             <= 8'd0;
      c_q             <= 9'd0;
      total_q         <= '0;
      addr_q          <= '0;
      col_q           <= 8'd0;
      row_q           <= 8'd0;
      ch_q            <= 9'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && tag_last;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            n_q     <= Image_size;
            c_q     <= Channel_size;
            total_q <= TOTAL_WIDTH'(Channel_size) * TOTAL_WIDTH'(Image_size)
                       * TOTAL_WIDTH'(Image_size);
            addr_q  <= '0;
            col_q   <= 8'd0;
            row_q   <= 8'd0;
            ch_q    <= 9'd0;
            state_q <= ((Image_size == 8'd0) || (Channel_size == 9'd0)) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            if (col_q == n_q - 8'd1) begin
              col_q <= 8'd0;
              if (row_q == n_q - 8'd1) begin
                row_q <= 8'd0;
                ch_q  <= (ch_q == c_q - 9'd1) ? 9'd0 : ch_q + 9'd1;
              end else begin
                row_q <= row_q + 8'd1;
              end
            end else begin
              col_q <= col_q + 8'd1;
            end
            if (final_read) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drained) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          addr_q  <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  stream_fifo2 #(.W(EW)) u_fifo (
    .clk     (clk),
    .resetn  (aresetn),
    .push_i  (inflight_q),
    .data_i  ({inflight_last_q, fmap_BRAM_dout}),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign fmap_BRAM_en   = issue;
  assign fmap_BRAM_addr = addr_q;
  assign m_axis.tvalid  = fifo_valid;
  assign m_axis.tdata   = head[PIXEL_WIDTH-1:0];
  assign m_axis.tlast   = head[PIXEL_WIDTH];

endmodule

// File: tb/tb_conv_input_streamer.sv
// tb/tb_conv_input_streamer.sv - scoreboard bench for conv_input_streamer
module tb_conv_input_streamer;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  img = 8'd0;
  logic [8:0]  chn = 9'd0;
  logic        busy, done, en;
  logic [21:0] addr;
  logic [15:0] dout = 16'd0;

  conv_input_streamer_if #(.PIXEL_WIDTH(16)) axis ();

  conv_input_streamer #(.ADDR_WIDTH(22), .PIXEL_WIDTH(16)) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .start          (start),
    .Image_size     (img),
    .Channel_size   (chn),
    .busy           (busy),
    .done           (done),
    .fmap_BRAM_en   (en),
    .fmap_BRAM_addr (addr),
    .fmap_BRAM_dout (dout),
    .m_axis         (axis)
  );

  always #5 clk = ~clk;

  // BRAM model: mem[i] = i + 0x100, one-cycle read latency
  always @(posedge clk) if (en) dout <= 16'(addr + 22'h100);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic last; logic [15:0] data; } beat_t;
  beat_t sb[$];

  typedef struct { int n; int c; int mode; int exp_beats; int exp_stall_en; } vec_t;
  vec_t tbl[7];

  int n_cmp = 0, n_bad = 0;
  int beats, en_cnt, stall_en, done_cnt, done_cyc, first_tv, first_hs, last_hs;
  logic stall_win = 1'b0, prev_stall = 1'b0, prev_done = 1'b0, prev_last = 1'b0;
  logic [15:0] prev_data = 16'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!aresetn) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_tvalid", axis.tvalid, 1);
        check("hold_tdata", axis.tdata, prev_data);
        check("hold_tlast", axis.tlast, prev_last);
      end
      if (axis.tvalid && first_tv < 0) first_tv = cyc;
      if (axis.tvalid && axis.tready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", axis.tdata);
        end else begin
          e = sb.pop_front();
          check("tdata", axis.tdata, e.data);
          check("tlast", axis.tlast, e.last);
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        beats++;
      end
      if (en) en_cnt++;
      if (en && stall_win) stall_en++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_with_done", busy, 1);
      end
      if (prev_done) check("busy_after_done", busy, 0);
      prev_stall = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;
      prev_last  = axis.tlast;
      prev_done  = done;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_en"}, en, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_tvalid"}, axis.tvalid, 0);
    check({tag, "_tlast"}, axis.tlast, 0);
    check({tag, "_tdata"}, axis.tdata, 0);
  endtask

  // mode: 0 = tready high, 1 = random tready, 2 = tready low for 10 cycles then high
  task automatic run_case(input int n, input int c, input int mode, input int restart_k,
                          input int reset_beats, input int exp_beats, input int exp_stall_en);
    int  total, s_cyc, k;
    bit  stop, did_reset;
    beat_t b;
    beats = 0; en_cnt = 0; stall_en = 0; done_cnt = 0;
    done_cyc = -1; first_tv = -1; first_hs = -1; last_hs = -1;
    sb.delete();
    total = n * c * n;
    for (int i = 0; i < total; i++) begin
      b.last = ((i % (n * n)) == (n * n - 1));
      b.data = 16'(i + 256);
      sb.push_back(b);
    end
    img = 8'(n); chn = 9'(c); start = 1'b1;
    axis.tready = (mode == 2) ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
    k = 0; stop = 0; did_reset = 0;
    while (!stop && k < 2000) begin
      case (mode)
        1:       axis.tready = 1'($urandom_range(0, 1));
        2:       axis.tready = (k >= 10);
        default: axis.tready = 1'b1;
      endcase
      stall_win = (mode == 2) && (k < 10);
      if (k == restart_k) begin
        start = 1'b1;
        img   = 8'd8;
      end else begin
        start = 1'b0;
      end
      if (reset_beats >= 0 && !did_reset && beats >= reset_beats) begin
        aresetn   = 1'b0;
        did_reset = 1;
      end
      @(posedge clk); #1;
      if (!aresetn) begin
        aresetn = 1'b1;
        check_reset_outputs("midreset");
        stop = 1;
      end
      if (done_cnt > 0 && cyc > done_cyc + 1) stop = 1;
      k++;
    end
    start = 1'b0;
    stall_win = 1'b0;
    axis.tready = 1'b1;
    if (did_reset) begin
      sb.delete();
    end else begin
      check("timeout", (k < 2000), 1);
      check("beat_count", beats, exp_beats);
      check("done_count", done_cnt, 1);
      check("scoreboard_empty", sb.size(), 0);
      if (exp_beats == 0) begin
        check("zero_done_latency", done_cyc, s_cyc);
        check("zero_en_count", en_cnt, 0);
        check("zero_no_tvalid", first_tv, -1);
      end else if (mode == 0) begin
        check("first_tvalid_latency", first_tv, s_cyc + 2);
        check("no_bubbles", last_hs - first_hs, exp_beats - 1);
        check("done_after_last", done_cyc, last_hs + 1);
      end
      if (exp_stall_en >= 0) check("stall_en_pulses", stall_en, exp_stall_en);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{2, 2, 0, 8, -1};
    tbl[1] = '{2, 2, 1, 8, -1};
    tbl[2] = '{4, 1, 2, 16, 2};
    tbl[3] = '{0, 3, 0, 0, -1};
    tbl[4] = '{3, 0, 0, 0, -1};
    tbl[5] = '{1, 1, 0, 1, -1};
    tbl[6] = '{3, 2, 1, 18, -1};

    axis.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    aresetn = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      run_case(tbl[v].n, tbl[v].c, tbl[v].mode, -1, -1, tbl[v].exp_beats, tbl[v].exp_stall_en);
    end

    // start re-pulsed mid-stream with a different size must be ignored
    run_case(4, 1, 0, 6, -1, 16, -1);

    // reset after 5 beats, then a fresh stream must restart at 0x100
    run_case(4, 2, 0, -1, 5, 32, -1);
    run_case(4, 1, 0, -1, -1, 16, -1);
    run_case(2, 2, 1, -1, -1, 8, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
